// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          Q_DEPTH_DEFAULT  = 2;

   // IDLE may issue, WAIT has one request in flight, DROP discards the in-flight response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // One queue entry: fetch address in the upper half, instruction word in the lower half.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; DEPTH must be a power of two.
// The head entry comes straight from storage registers, so the outputs never
// see the incoming push data combinationally.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = Q_DEPTH_DEFAULT,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic [PTR_W:0]     count,
   output logic               full,
   output logic               empty
);

   fetch_entry_t     slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   // Storage, pointers and occupancy; flush discards everything in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_data;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, responses
// queued in order for decode, and redirects that flush and retarget fetch.
//
// Handshakes: the memory accepts a request in every cycle imem_req is high,
// and returns exactly one imem_rvalid pulse per request, one or more cycles
// later. On the decode side an instruction moves when instr_valid and
// instr_ready are both high at a rising edge; instr_valid never depends on
// instr_ready, and a redirect in the same cycle cancels the move.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          Q_DEPTH  = Q_DEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic         instr_valid,
   output logic [31:0]  instr,
   output logic [31:0]  instr_pc,
   input  logic         instr_ready,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output fetch_state_t dbg_state
);

   localparam int PTR_W = $clog2(Q_DEPTH);

   fetch_state_t   state;
   fetch_state_t   state_nxt;
   logic [31:0]    fetch_pc;
   logic [31:0]    fetch_pc_nxt;
   logic [31:0]    target_pc;
   logic           push;
   logic           pop;
   logic           can_fetch;
   fetch_entry_t   q_head;
   logic [PTR_W:0] q_count;
   logic           q_full;
   logic           q_empty;

   // Low address bits of a jump target are meaningless for word fetches.
   assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
   assign can_fetch   = (q_count < (PTR_W+1)'(Q_DEPTH));
   assign pop         = !q_empty && instr_ready && !redirect;
   assign imem_addr   = fetch_pc;
   assign instr_valid = !q_empty;
   assign instr       = q_head.instr;
   assign instr_pc    = q_head.pc;
   assign dbg_state   = state;

   // FSM state and fetch address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   // Next state, next fetch address, request issue and queue push.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      imem_req     = 1'b0;
      push         = 1'b0;
      unique case (state)
         IDLE: begin
            // A stray response here has no owner and is ignored.
            if (redirect) begin
               fetch_pc_nxt = target_pc;
            end else if (can_fetch && rst_n) begin
               imem_req  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_pc_nxt = target_pc;
               state_nxt    = imem_rvalid ? IDLE : DROP;
            end else if (imem_rvalid) begin
               push         = !q_full || pop;
               fetch_pc_nxt = fetch_pc + 32'd4;
               state_nxt    = IDLE;
            end
         end
         DROP: begin
            if (redirect) begin
               fetch_pc_nxt = target_pc;
            end
            if (imem_rvalid) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   fetch_queue #(
      .DEPTH (Q_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({fetch_pc, imem_rdata}),
      .pop       (pop),
      .flush     (redirect),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter Q_DEPTH, default 2: instruction queue entries; legal values 2 and 4.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port imem_req, output, 1 bit: fetch request, accepted by memory in the cycle it is high.
REQ-006 Port imem_addr, output, 32 bits: word-aligned fetch address; valid while imem_req is high.
REQ-007 Port imem_rvalid, input, 1 bit: response strobe, arriving 1 or more cycles after the request.
REQ-008 Port imem_rdata, input, 32 bits: instruction word; valid with imem_rvalid.
REQ-009 Port instr_valid, output, 1 bit: queue head is valid.
REQ-010 Port instr, output, 32 bits: queue-head instruction word, driven to the decode/control stage.
REQ-011 Port instr_pc, output, 32 bits: address of the queue-head instruction.
REQ-012 Port instr_ready, input, 1 bit: decode consumes the head; a pop occurs when instr_valid and instr_ready are both high.
REQ-013 Port redirect, input, 1 bit: taken branch, JAL or JALR (PCsrc) from the execute side.
REQ-014 Port redirect_pc, input, 32 bits: new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-015 The FSM SHALL have three states:
- IDLE: may issue a request.
- WAIT: one request outstanding.
- DROP: outstanding response is to be discarded.
REQ-016 In IDLE, imem_req SHALL equal (count < Q_DEPTH) && !redirect, with imem_addr = fetch_pc; when issued, the next state SHALL be WAIT.
REQ-017 At most one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and DROP.
REQ-018 In WAIT, on imem_rvalid the unit SHALL push {fetch_pc, imem_rdata} into the queue, set fetch_pc = fetch_pc + 4, and return to IDLE.
REQ-019 fetch_pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
REQ-020 Latency: a response pushed in cycle N SHALL be visible at the outputs (instr_valid = 1) in cycle N+1.
REQ-021 Throughput: at most one instruction every 2 cycles with 1-cycle memory latency.
REQ-022 Queue order SHALL be FIFO; instr and instr_pc SHALL come from a registered head, with no combinational path from imem_rdata.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged.
REQ-024 Redirect in IDLE SHALL flush the queue, load fetch_pc = {redirect_pc[31:2], 2'b00}, issue no request that cycle, and remain in IDLE.
REQ-025 Redirect in WAIT without imem_rvalid SHALL flush the queue, load the new fetch_pc, and go to DROP.
REQ-026 Redirect in WAIT with imem_rvalid SHALL flush the queue, discard the response, load the new fetch_pc, and go to IDLE.
REQ-027 In DROP, imem_rvalid SHALL be discarded with no push and return the FSM to IDLE; a further redirect in DROP SHALL only reload fetch_pc.
REQ-028 Redirect SHALL take priority over a simultaneous pop; instr_valid SHALL be 0 in the cycle after any redirect.
REQ-029 imem_rvalid in IDLE (protocol error) SHALL be ignored.
REQ-030 When the queue is full, no request SHALL be issued; there SHALL be no overflow.
REQ-031 When the queue is empty, instr_valid SHALL be 0 and a pop SHALL have no effect.

Reset
REQ-032 On rst_n low, asynchronously: state = IDLE, fetch_pc = RESET_PC, count = 0, queue pointers = 0, instr_valid = 0, imem_req = 0.
REQ-033 On rst_n low: instr = 0, instr_pc = 0, imem_addr = RESET_PC.
REQ-034 The first request SHALL issue in the first cycle after rst_n deasserts.
REQ-035 A response arriving after a reset asserted mid-WAIT SHALL be ignored, since the FSM is then in IDLE.

Structure
REQ-036 Package cpu_pkg SHALL hold RESET_PC_DEFAULT, Q_DEPTH_DEFAULT, the fetch_state_t enum (IDLE, WAIT, DROP) and the 64-bit fetch_entry_t struct {pc, instr}.
REQ-037 Sub-module fetch_queue SHALL implement the synchronous FIFO with push, pop, flush, count, full and empty; fetch_unit SHALL instantiate it once.

Verification
REQ-038 Reset release, 1-cycle memory returning 32'h00500093 → imem_req=1, addr 0 in cycle 1; instr_valid=1, instr=32'h00500093, instr_pc=0 in cycle 3.
REQ-039 instr_ready=0 for 10 cycles → exactly Q_DEPTH pushes (pc 0, 4), imem_req=0 thereafter; releasing ready pops in order 0 then 4.
REQ-040 Redirect to 32'h0000_0102 during WAIT, response 3 cycles later → response dropped; next imem_addr=32'h0000_0100; no instr_valid with pc 0.
REQ-041 Redirect coincident with imem_rvalid and instr_ready on a full queue → queue empty next cycle, FSM in IDLE, next request issued at the redirect target.
REQ-042 RESET_PC=32'hFFFF_FFFC → second request address 32'h0000_0000.
REQ-043 rst_n pulsed low mid-WAIT, then a stale imem_rvalid → no push; fetch restarts at RESET_PC.
